// File: rtl/reg_file_wb_pkg.sv
// Shared RISC-V register-file types: register addressing, read-request bundle,
// and the scoreboard counter operation encoding.
package rv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic              use_en;
    } rf_rd_t;

    typedef enum logic [1:0] {
        SB_HOLD = 2'd0,
        SB_INC  = 2'd1,
        SB_DEC  = 2'd2
    } sb_op_e;

    // Simultaneous issue and write-back on the same register cancel out.
    function automatic sb_op_e sb_op(input logic inc, input logic dec);
        if (inc && !dec) return SB_INC;
        if (dec && !inc) return SB_DEC;
        return SB_HOLD;
    endfunction

endpackage

// File: rtl/reg_file_wb_if.sv
// Decode/write-back side bus of the register file: write-back, read request,
// issue tracking, read data and stall/error status.
interface reg_file_wb_if #(
    parameter int unsigned XLEN = rv_pkg::XLEN,
    parameter int unsigned AW   = rv_pkg::REG_AW
) ();
    logic            wb_en;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            rd_en;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            rs1_use;
    logic            rs2_use;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            hazard;
    logic            sb_err;

    modport master (
        output wb_en, wb_rd, wb_data, rd_en, rs1_addr, rs2_addr,
               rs1_use, rs2_use, iss_en, iss_rd,
        input  rs1_data, rs2_data, hazard, sb_err
    );

    modport slave (
        input  wb_en, wb_rd, wb_data, rd_en, rs1_addr, rs2_addr,
               rs1_use, rs2_use, iss_en, iss_rd,
        output rs1_data, rs2_data, hazard, sb_err
    );
endinterface

// File: rtl/reg_file_wb_sb_cell.sv
// Saturating pending-writer counter for one architectural register; flags
// increment-at-max and decrement-at-zero for the top-level sticky error.
module sb_cell
    import rv_pkg::*;
#(
    parameter int unsigned PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [PEND_W-1:0] cnt_o,
    output logic              ovf_o,
    output logic              unf_o
);
    logic [PEND_W-1:0] cnt_q, cnt_d;
    sb_op_e            op;

    always_comb begin
        op    = sb_op(inc_i, dec_i);
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        unf_o = 1'b0;
        case (op)
            SB_INC: if (cnt_q == '1) ovf_o = 1'b1;
                    else             cnt_d = cnt_q + PEND_W'(1);
            SB_DEC: if (cnt_q == '0) unf_o = 1'b1;
                    else             cnt_d = cnt_q - PEND_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/reg_file_wb.sv
// Integer register file with write-first bypass on two registered read ports,
// per-register pending-write scoreboard driving a combinational decode stall.
module reg_file_wb
    import rv_pkg::*;
#(
    parameter int unsigned XLEN   = rv_pkg::XLEN,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned PEND_W = 2
) (
    input  logic           clk,
    input  logic           rst,
    reg_file_wb_if.slave   bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]   regs_q  [NREGS];
    logic [XLEN-1:0]   rdata_q [2];
    logic [XLEN-1:0]   rdata_d [2];
    logic [AW-1:0]     raddr   [2];
    logic              bypass  [2];
    logic              pend    [2];
    logic              haz     [2];
    logic [PEND_W-1:0] cnt     [NREGS];
    logic [NREGS-1:0]  ovf, unf;
    logic              sb_err_q;
    rf_rd_t            req     [2];

    assign req[0] = '{addr: REG_AW'(bus.rs1_addr), use_en: bus.rs1_use};
    assign req[1] = '{addr: REG_AW'(bus.rs2_addr), use_en: bus.rs2_use};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (bus.wb_en && bus.wb_rd != AW'(REG_X0)) begin
            regs_q[bus.wb_rd] <= bus.wb_data;
        end
    end

    // A final write-back (count 1) landing this cycle is covered by the bypass.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            raddr[p]   = req[p].addr[AW-1:0];
            bypass[p]  = bus.wb_en && (bus.wb_rd == raddr[p]);
            rdata_d[p] = rdata_q[p];
            if (bus.rd_en) begin
                if (raddr[p] == AW'(REG_X0)) rdata_d[p] = '0;
                else if (bypass[p])          rdata_d[p] = bus.wb_data;
                else                         rdata_d[p] = regs_q[raddr[p]];
            end
            pend[p] = (cnt[raddr[p]] != '0) &&
                      !((cnt[raddr[p]] == PEND_W'(1)) && bypass[p]);
            haz[p]  = req[p].use_en && (raddr[p] != AW'(REG_X0)) && pend[p];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
            if (|ovf || |unf) sb_err_q <= 1'b1;
        end
    end

    assign cnt[0] = '0;
    assign ovf[0] = 1'b0;
    assign unf[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_sb
        sb_cell #(.PEND_W(PEND_W)) u_sb (
            .clk   (clk),
            .rst   (rst),
            .inc_i (bus.iss_en && (bus.iss_rd == AW'(r))),
            .dec_i (bus.wb_en && (bus.wb_rd == AW'(r))),
            .cnt_o (cnt[r]),
            .ovf_o (ovf[r]),
            .unf_o (unf[r])
        );
    end

    assign bus.rs1_data = rdata_q[0];
    assign bus.rs2_data = rdata_q[1];
    assign bus.hazard   = haz[0] | haz[1];
    assign bus.sb_err   = sb_err_q;
endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed scenarios plus randomized
// traffic compared against an array/integer reference model.
module tb_reg_file_wb;
    localparam int NR     = 32;
    localparam int PMAX   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_file_wb_if #(.XLEN(32), .AW(5)) bus ();

    reg_file_wb #(.XLEN(32), .NREGS(32), .PEND_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] m_regs [NR];
    int          m_cnt  [NR];
    logic        m_err;
    logic [31:0] m_rs1, m_rs2;

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'h0;
        if (bus.wb_en && int'(bus.wb_rd) == a) return bus.wb_data;
        return m_regs[a];
    endfunction

    // Apply one clock edge of the reference model using the current inputs.
    function automatic void model_edge();
        if (rst) begin
            for (int i = 0; i < NR; i++) begin m_regs[i] = 0; m_cnt[i] = 0; end
            m_err = 0; m_rs1 = 0; m_rs2 = 0;
            return;
        end
        if (bus.rd_en) begin
            m_rs1 = m_read(int'(bus.rs1_addr));
            m_rs2 = m_read(int'(bus.rs2_addr));
        end
        for (int r = 1; r < NR; r++) begin
            bit inc, dec;
            inc = bus.iss_en && int'(bus.iss_rd) == r;
            dec = bus.wb_en && int'(bus.wb_rd) == r;
            if (inc && !dec) begin
                if (m_cnt[r] == PMAX) m_err = 1; else m_cnt[r]++;
            end else if (dec && !inc) begin
                if (m_cnt[r] == 0) m_err = 1; else m_cnt[r]--;
            end
        end
        if (bus.wb_en && bus.wb_rd != 0) m_regs[bus.wb_rd] = bus.wb_data;
    endfunction

    function automatic bit m_port_haz(input bit use_i, input int a);
        bit covered;
        if (!use_i || a == 0) return 0;
        covered = bus.wb_en && int'(bus.wb_rd) == a;
        return (m_cnt[a] > 1) || (m_cnt[a] == 1 && !covered);
    endfunction

    function automatic bit m_hazard();
        return m_port_haz(bus.rs1_use, int'(bus.rs1_addr)) |
               m_port_haz(bus.rs2_use, int'(bus.rs2_addr));
    endfunction

    task automatic idle();
        bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
        bus.rd_en = 0; bus.rs1_addr = 0; bus.rs2_addr = 0;
        bus.rs1_use = 0; bus.rs2_use = 0; bus.iss_en = 0; bus.iss_rd = 0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; bus.rd_en = 1; bus.rs1_addr = 5; bus.rs2_addr = 31;
        tick();
        rst = 0; idle(); #1;
        n_checks++; if (bus.rs1_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs1: got %h exp 0", bus.rs1_data); end
        n_checks++; if (bus.rs2_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs2: got %h exp 0", bus.rs2_data); end
        n_checks++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b exp 0", bus.hazard); end
        n_checks++; if (bus.sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_sb_err: got %b exp 0", bus.sb_err); end
    endtask

    task automatic test_write_read();
        idle(); bus.wb_en = 1; bus.wb_rd = 3; bus.wb_data = 32'hDEAD_BEEF; tick();
        idle(); bus.rd_en = 1; bus.rs1_addr = 3; tick();
        idle(); #1;
        n_checks++; if (bus.rs1_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rd_x3: got %h exp deadbeef", bus.rs1_data); end
        bus.wb_en = 1; bus.wb_rd = 0; bus.wb_data = 32'hFFFF_FFFF; tick();
        idle(); bus.rd_en = 1; bus.rs1_addr = 0; bus.rs2_addr = 3; tick();
        idle(); #1;
        n_checks++; if (bus.rs1_data !== 32'h0) begin n_fail++; $display("FAIL rd_x0: got %h exp 0", bus.rs1_data); end
        n_checks++; if (bus.rs2_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_x3_port2: got %h exp deadbeef", bus.rs2_data); end
        // rd_en low: outputs hold
        bus.rd_en = 0; bus.rs1_addr = 3; tick();
        n_checks++; if (bus.rs1_data !== 32'h0) begin n_fail++; $display("FAIL rd_hold: got %h exp 0", bus.rs1_data); end
    endtask

    task automatic test_bypass();
        idle(); bus.wb_en = 1; bus.wb_rd = 7; bus.wb_data = 32'h1234_5678;
        bus.rd_en = 1; bus.rs1_addr = 7; bus.rs2_addr = 7; tick();
        idle(); #1;
        n_checks++; if (bus.rs1_data !== 32'h1234_5678) begin n_fail++; $display("FAIL bypass_rs1: got %h exp 12345678", bus.rs1_data); end
        n_checks++; if (bus.rs2_data !== 32'h1234_5678) begin n_fail++; $display("FAIL bypass_rs2: got %h exp 12345678", bus.rs2_data); end
    endtask

    task automatic test_hazard();
        do_reset();
        idle(); bus.iss_en = 1; bus.iss_rd = 4;
        #1;
        n_checks++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL haz_iss_same_cycle: got %b exp 0", bus.hazard); end
        tick();
        idle(); bus.rs2_addr = 4; bus.rs2_use = 1; #1;
        n_checks++; if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL haz_rs2_pending: got %b exp 1", bus.hazard); end
        bus.rs2_use = 0; #1;
        n_checks++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL haz_rs2_unused: got %b exp 0", bus.hazard); end
        bus.rs2_use = 1; bus.wb_en = 1; bus.wb_rd = 4; bus.wb_data = 32'hA5A5_0004; #1;
        n_checks++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL haz_wb_covers: got %b exp 0", bus.hazard); end
        tick();
        idle(); bus.rs2_addr = 4; bus.rs2_use = 1; #1;
        n_checks++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL haz_cleared: got %b exp 0", bus.hazard); end
    endtask

    task automatic test_overflow_underflow();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            idle(); bus.iss_en = 1; bus.iss_rd = 9; tick();
            n_checks++;
            if (bus.sb_err !== (k == 4)) begin n_fail++; $display("FAIL ovf_issue%0d: got %b exp %b", k, bus.sb_err, k == 4); end
        end
        // Count must be 3: hazard persists through two write-backs, cleared by the third.
        for (int k = 1; k <= 3; k++) begin
            idle(); bus.rs1_addr = 9; bus.rs1_use = 1;
            bus.wb_en = 1; bus.wb_rd = 9; bus.wb_data = $urandom; #1;
            n_checks++;
            if (bus.hazard !== (k != 3)) begin n_fail++; $display("FAIL ovf_drain%0d: got %b exp %b", k, bus.hazard, k != 3); end
            tick();
        end
        do_reset();
        idle(); bus.wb_en = 1; bus.wb_rd = 10; bus.wb_data = 32'hCAFE_F00D; tick();
        n_checks++; if (bus.sb_err !== 1'b1) begin n_fail++; $display("FAIL unf_sb_err: got %b exp 1", bus.sb_err); end
        idle(); bus.rd_en = 1; bus.rs2_addr = 10; tick();
        n_checks++; if (bus.rs2_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL unf_write: got %h exp cafef00d", bus.rs2_data); end
        n_checks++; if (bus.sb_err !== 1'b1) begin n_fail++; $display("FAIL sb_err_sticky: got %b exp 1", bus.sb_err); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        idle(); bus.iss_en = 1; bus.iss_rd = 6; tick();
        bus.wb_en = 1; bus.wb_rd = 6; bus.wb_data = 32'h0000_0066; tick();
        idle(); bus.rs1_addr = 6; bus.rs1_use = 1; #1;
        n_checks++; if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL same_cycle_haz: got %b exp 1", bus.hazard); end
        n_checks++; if (bus.sb_err !== 1'b0) begin n_fail++; $display("FAIL same_cycle_err: got %b exp 0", bus.sb_err); end
        rst = 1; tick(); rst = 0; #1;
        n_checks++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL rst_mid_haz: got %b exp 0", bus.hazard); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 39) == 0);
            bus.wb_en    = ($urandom_range(0, 2) == 0);
            bus.wb_rd    = 5'($urandom_range(0, 7));
            bus.wb_data  = $urandom;
            bus.iss_en   = ($urandom_range(0, 2) == 0);
            bus.iss_rd   = 5'($urandom_range(0, 7));
            bus.rd_en    = $urandom_range(0, 1);
            bus.rs1_addr = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            bus.rs2_addr = 5'($urandom_range(0, 7));
            bus.rs1_use  = $urandom_range(0, 1);
            bus.rs2_use  = $urandom_range(0, 1);
            #1;
            n_checks++; if (bus.hazard !== m_hazard()) begin n_fail++; $display("FAIL rnd_hazard c%0d: got %b exp %b", c, bus.hazard, m_hazard()); end
            tick();
            n_checks++; if (bus.rs1_data !== m_rs1) begin n_fail++; $display("FAIL rnd_rs1 c%0d: got %h exp %h", c, bus.rs1_data, m_rs1); end
            n_checks++; if (bus.rs2_data !== m_rs2) begin n_fail++; $display("FAIL rnd_rs2 c%0d: got %h exp %h", c, bus.rs2_data, m_rs2); end
            n_checks++; if (bus.sb_err !== m_err) begin n_fail++; $display("FAIL rnd_sb_err c%0d: got %b exp %b", c, bus.sb_err, m_err); end
        end
        rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        for (int i = 0; i < NR; i++) begin m_regs[i] = 0; m_cnt[i] = 0; end
        m_err = 0; m_rs1 = 0; m_rs2 = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_hazard();
        test_overflow_underflow();
        test_same_cycle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
